mem_request_unit: RTL and testbench

- Sits between the single-cycle datapath and the single-ported RAM.
- Consumes the decoded memory-intent signals from the control unit (dREN_c, dWEN_c, halt_c) and sequences RAM instruction fetches and data accesses.
- Generates ihit/dhit back to the datapath and a PC enable.
- Registered grant FSM: data requests take priority, grants are never switched mid-transaction, RAM errors are retried and counted.

---
 rtl/mem_request_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_request_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
// mem_request_unit
// Sequences single-ported RAM accesses for a single-cycle core: instruction
// fetches and the data accesses they decode to share one RAM port. A registered
// grant FSM gives pending data accesses priority over the next fetch, never
// switches grant mid-transaction, and retries any access that returns ERROR.
// Hit and RAM request outputs decode from the registered state (plus ramstate
// for the hits), so an asynchronous reset silences them immediately.

module mem_request_unit #(
  parameter int WORD_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  // decoded memory intent from the control unit, valid during the ihit cycle
  input  logic              dREN_c,
  input  logic              dWEN_c,
  input  logic              halt_c,
  // datapath addresses and store data
  input  logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  // back to the datapath
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ihit,
  output logic              dhit,
  output logic              pc_en,
  output logic              halt,
  output logic [ERR_W-1:0]  err_cnt,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  // RAM handshake encodings that change the FSM; FREE and BUSY both mean "wait"
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              dren_q, dren_d;
  logic              dwen_q, dwen_d;
  logic              halt_q, halt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              ram_err;

  // RAM read data is forwarded unregistered to both consumers
  assign iload   = ramload;
  assign dload   = ramload;
  assign pc_en   = ihit;
  assign halt    = halt_q;
  assign err_cnt = err_cnt_q;

  // An ERROR response only counts while a request is actually outstanding
  assign ram_err = (ramstate == RAM_ERROR) &&
                   ((state_q == IFETCH) || (state_q == DACCESS));

  // State, pending-access, halt and error-count registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      halt_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dren_q    <= dren_d;
      dwen_q    <= dwen_d;
      halt_q    <= halt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Saturating error counter: holds at all-ones rather than wrapping
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ram_err && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Grant FSM: next state, pending-intent capture, RAM requests and hits
  always_comb begin
    state_d  = state_q;
    dren_d   = dren_q;
    dwen_d   = dwen_q;
    halt_d   = halt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // a pending data access always beats halting or fetching, so a
        // load/store carried by the halt instruction still completes
        if (dren_q || dwen_q) begin
          state_d = DACCESS;
        end else if (halt_q) begin
          state_d = HALTED;
        end else begin
          state_d = IFETCH;
        end
      end

      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == RAM_ACCESS) begin
          ihit    = 1'b1;
          // the decoded intent belongs to the instruction just returned
          dren_d  = dREN_c;
          dwen_d  = dWEN_c;
          if (halt_c) begin
            halt_d = 1'b1;
          end
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          // drop back to IDLE and re-issue the same fetch next time round
          state_d = IDLE;
        end
      end

      DACCESS: begin
        ramREN   = dren_q;
        ramWEN   = dwen_q;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ramstate == RAM_ACCESS) begin
          dhit    = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          // intents stay pending so IDLE re-enters DACCESS for the retry
          state_d = IDLE;
        end
      end

      HALTED: begin
        // terminal: only reset leaves this state
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read and write together is an illegal decode; the RAM decides the outcome
  illegal_rw_a: assert property (@(posedge CLK) disable iff (!nRST)
    !((state_q == DACCESS) && dren_q && dwen_q));

endmodule

// File: tb/tb_mem_request_unit.sv
// Self-checking bench for mem_request_unit. Inputs change on the falling edge,
// outputs are sampled 1 time unit later. Each expected transaction is queued
// when its stimulus is set up and popped when the DUT signals the hit.

module tb_mem_request_unit;

  localparam int WORD_W = 32;
  localparam int ERR_W  = 8;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam logic [31:0] KEY   = 32'h5A5A_0F0F;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              dREN_c, dWEN_c, halt_c;
  logic [WORD_W-1:0] iaddr, daddr, dstore;
  logic [WORD_W-1:0] iload, dload;
  logic              ihit, dhit, pc_en, halt;
  logic [ERR_W-1:0]  err_cnt;
  logic              ramREN, ramWEN;
  logic [WORD_W-1:0] ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  // RAM model: the word at an address is the address xor a fixed key
  assign ramload = ramaddr ^ KEY;

  always #5 CLK = ~CLK;

  mem_request_unit #(.WORD_W(WORD_W), .ERR_W(ERR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_c(dREN_c), .dWEN_c(dWEN_c), .halt_c(halt_c),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iload(iload), .dload(dload),
    .ihit(ihit), .dhit(dhit), .pc_en(pc_en), .halt(halt), .err_cnt(err_cnt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Hold reset for one cycle, release at a falling edge: the current cycle is IDLE
  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; ramstate = FREE; dREN_c = 1'b0; dWEN_c = 1'b0; halt_c = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    sb.delete();
  endtask

  task automatic test_reset();
    nRST = 1'b0; dREN_c = 1'b0; dWEN_c = 1'b0; halt_c = 1'b0;
    iaddr = 32'h40; daddr = 32'h0; dstore = 32'h0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({ramREN, ramWEN, ihit, dhit, pc_en, halt} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=000000", {ramREN, ramWEN, ihit, dhit, pc_en, halt});
    end
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      errors++; $display("FAIL reset_bus addr=%h store=%h want 0/0", ramaddr, ramstore);
    end
    @(negedge CLK); nRST = 1'b1; ramstate = BUSY; #1;
    checks++;
    if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_first_idle ramREN=%b want=0", ramREN); end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      errors++; $display("FAIL reset_first_fetch ramREN=%b addr=%h want 1/00000040", ramREN, ramaddr);
    end
    @(negedge CLK); #1;
    nRST = 1'b0; #1;
    checks++;
    if (ramREN !== 1'b0 || ihit !== 1'b0 || ramaddr !== 32'h0) begin
      errors++; $display("FAIL reset_mid_fetch ramREN=%b ihit=%b addr=%h want 0/0/0", ramREN, ihit, ramaddr);
    end
    @(negedge CLK); nRST = 1'b1; #1;
    checks++;
    if (ramREN !== 1'b0) begin errors++; $display("FAIL rerelease_idle ramREN=%b want=0", ramREN); end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      errors++; $display("FAIL rerelease_fetch ramREN=%b addr=%h want 1/00000040", ramREN, ramaddr);
    end
  endtask

  task automatic test_fetch_stream();
    exp_t e;
    logic [31:0] pc;
    logic exp_hit;
    bit advance;
    int fetched;
    do_reset();
    pc = 32'h1000; iaddr = pc; ramstate = ACCESS; advance = 0; fetched = 0;
    sb.push_back('{kind: 0, addr: pc, data: pc ^ KEY});
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (advance) begin
        pc = pc + 32'd4; iaddr = pc; advance = 0;
        sb.push_back('{kind: 0, addr: pc, data: pc ^ KEY});
      end
      #1;
      exp_hit = (c % 2 == 1);
      checks++;
      if (ihit !== exp_hit || pc_en !== exp_hit) begin
        errors++; $display("FAIL stream_hit cyc=%0d ihit=%b pc_en=%b want=%b", c, ihit, pc_en, exp_hit);
      end
      checks++;
      if (ramWEN !== 1'b0 || dhit !== 1'b0) begin
        errors++; $display("FAIL stream_no_data cyc=%0d ramWEN=%b dhit=%b want 0/0", c, ramWEN, dhit);
      end
      if (ihit === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (e.kind != 0 || ramaddr !== e.addr || iload !== e.data) begin
          errors++; $display("FAIL stream_txn addr=%h iload=%h want addr=%h iload=%h", ramaddr, iload, e.addr, e.data);
        end
        $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
        fetched++; advance = 1;
      end
    end
    checks++;
    if (fetched != 10) begin errors++; $display("FAIL stream_count got=%0d want=10", fetched); end
  endtask

  task automatic test_load();
    exp_t e;
    do_reset();
    iaddr = 32'h2000; daddr = 32'h100;
    sb.push_back('{kind: 0, addr: 32'h2000, data: 32'h2000 ^ KEY});
    @(negedge CLK); ramstate = ACCESS; dREN_c = 1'b1; #1;
    checks++;
    if (ihit !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL load_fetch_hit ihit=%b want=1", ihit);
    end else begin
      e = sb.pop_front();
      checks++;
      if (ramaddr !== e.addr || iload !== e.data) begin
        errors++; $display("FAIL load_fetch_txn addr=%h iload=%h want %h/%h", ramaddr, iload, e.addr, e.data);
      end
      $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
    end
    sb.push_back('{kind: 1, addr: 32'h100, data: 32'h100 ^ KEY});
    @(negedge CLK); dREN_c = 1'b0; ramstate = BUSY; #1;
    checks++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0 || ihit !== 1'b0) begin
      errors++; $display("FAIL load_idle ramREN=%b addr=%h ihit=%b want 0/0/0", ramREN, ramaddr, ihit);
    end
    for (int b = 1; b <= 4; b++) begin
      @(negedge CLK); ramstate = (b == 4) ? ACCESS : BUSY; #1;
      checks++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100 || dhit !== (b == 4) || ihit !== 1'b0) begin
        errors++; $display("FAIL load_daccess cyc=%0d REN=%b WEN=%b addr=%h dhit=%b ihit=%b want 1/0/00000100/%0d/0",
                           b, ramREN, ramWEN, ramaddr, dhit, ihit, (b == 4));
      end
      if (dhit === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (e.kind != 1 || dload !== e.data) begin
          errors++; $display("FAIL load_txn dload=%h want=%h", dload, e.data);
        end
        $display("TXN load addr=%h dload=%h", ramaddr, dload);
      end
    end
    @(negedge CLK); ramstate = BUSY; #1;
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h2000) begin
      errors++; $display("FAIL load_next_fetch REN=%b addr=%h want 1/00002000", ramREN, ramaddr);
    end
  endtask

  task automatic test_store();
    exp_t e;
    do_reset();
    iaddr = 32'h2400; daddr = 32'h200; dstore = 32'hDEADBEEF;
    sb.push_back('{kind: 0, addr: 32'h2400, data: 32'h2400 ^ KEY});
    @(negedge CLK); ramstate = ACCESS; dWEN_c = 1'b1; #1;
    checks++;
    if (ihit !== 1'b1 || ramstore !== 32'h0 || sb.size() == 0) begin
      errors++; $display("FAIL store_fetch ihit=%b ramstore=%h want 1/00000000", ihit, ramstore);
    end else begin
      e = sb.pop_front();
      $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
    end
    sb.push_back('{kind: 2, addr: 32'h200, data: 32'hDEADBEEF});
    @(negedge CLK); dWEN_c = 1'b0; ramstate = BUSY; #1;
    checks++;
    if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin
      errors++; $display("FAIL store_idle WEN=%b ramstore=%h want 0/0", ramWEN, ramstore);
    end
    for (int b = 1; b <= 2; b++) begin
      @(negedge CLK); ramstate = (b == 2) ? ACCESS : BUSY; #1;
      checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0 || dhit !== (b == 2)) begin
        errors++; $display("FAIL store_daccess cyc=%0d WEN=%b REN=%b ihit=%b dhit=%b want 1/0/0/%0d",
                           b, ramWEN, ramREN, ihit, dhit, (b == 2));
      end
      if (dhit === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (e.kind != 2 || ramaddr !== e.addr || ramstore !== e.data) begin
          errors++; $display("FAIL store_txn addr=%h ramstore=%h want %h/%h", ramaddr, ramstore, e.addr, e.data);
        end
        $display("TXN store addr=%h data=%h", ramaddr, ramstore);
      end
    end
    @(negedge CLK); ramstate = BUSY; #1;
    checks++;
    if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin
      errors++; $display("FAIL store_after_idle WEN=%b ramstore=%h want 0/0", ramWEN, ramstore);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h2400) begin
      errors++; $display("FAIL store_cleared REN=%b WEN=%b addr=%h want 1/0/00002400", ramREN, ramWEN, ramaddr);
    end
  endtask

  task automatic test_error_retry();
    exp_t e;
    do_reset();
    iaddr = 32'h3000;
    sb.push_back('{kind: 0, addr: 32'h3000, data: 32'h3000 ^ KEY});
    for (int a = 1; a <= 3; a++) begin
      @(negedge CLK); ramstate = (a == 3) ? ACCESS : ERROR; #1;
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h3000 || ihit !== (a == 3)) begin
        errors++; $display("FAIL retry_attempt n=%0d REN=%b addr=%h ihit=%b want 1/00003000/%0d", a, ramREN, ramaddr, ihit, (a == 3));
      end
      if (ihit === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (iload !== e.data) begin errors++; $display("FAIL retry_txn iload=%h want=%h", iload, e.data); end
        $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
      end
      @(negedge CLK); ramstate = FREE; #1;
      checks++;
      if (err_cnt !== 8'((a < 3) ? a : 2)) begin
        errors++; $display("FAIL retry_err_cnt n=%0d got=%0d want=%0d", a, err_cnt, (a < 3) ? a : 2);
      end
    end
  endtask

  task automatic test_err_saturate();
    int n;
    int want;
    do_reset();
    iaddr = 32'h5000; ramstate = ERROR; n = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge CLK); #1;
      if (c % 2 == 1) begin
        checks++;
        if (ramREN !== 1'b1 || ihit !== 1'b0) begin
          errors++; $display("FAIL sat_fetch cyc=%0d REN=%b ihit=%b want 1/0", c, ramREN, ihit);
        end
        n++;
      end else if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        want = (n > 255) ? 255 : n;
        checks++;
        if (err_cnt !== 8'(want)) begin
          errors++; $display("FAIL sat_err_cnt errs=%0d got=%0d want=%0d", n, err_cnt, want);
        end
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    do_reset();
    iaddr = 32'h4000;
    sb.push_back('{kind: 0, addr: 32'h4000, data: 32'h4000 ^ KEY});
    @(negedge CLK); ramstate = ACCESS; halt_c = 1'b1; #1;
    checks++;
    if (ihit !== 1'b1 || halt !== 1'b0 || sb.size() == 0) begin
      errors++; $display("FAIL halt_fetch ihit=%b halt=%b want 1/0", ihit, halt);
    end else begin
      e = sb.pop_front();
      $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
    end
    @(negedge CLK); halt_c = 1'b0; #1;
    checks++;
    if (halt !== 1'b1 || ramREN !== 1'b0) begin
      errors++; $display("FAIL halt_set halt=%b REN=%b want 1/0", halt, ramREN);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK); #1;
      checks++;
      if ({ramREN, ramWEN, ihit, dhit, pc_en} !== 5'b0 || halt !== 1'b1) begin
        errors++; $display("FAIL halted cyc=%0d req=%b halt=%b want 00000/1", c, {ramREN, ramWEN, ihit, dhit, pc_en}, halt);
      end
    end
    @(negedge CLK); nRST = 1'b0; #1;
    checks++;
    if (halt !== 1'b0) begin errors++; $display("FAIL halt_cleared halt=%b want=0", halt); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_halt_with_data();
    exp_t e;
    do_reset();
    iaddr = 32'h4800; daddr = 32'h500;
    sb.push_back('{kind: 0, addr: 32'h4800, data: 32'h4800 ^ KEY});
    @(negedge CLK); ramstate = ACCESS; halt_c = 1'b1; dREN_c = 1'b1; #1;
    if (ihit === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      $display("TXN fetch addr=%h iload=%h", ramaddr, iload);
    end
    sb.push_back('{kind: 1, addr: 32'h500, data: 32'h500 ^ KEY});
    @(negedge CLK); halt_c = 1'b0; dREN_c = 1'b0; #1;
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h500 || dhit !== 1'b1 || halt !== 1'b1) begin
      errors++; $display("FAIL halt_data REN=%b addr=%h dhit=%b halt=%b want 1/00000500/1/1", ramREN, ramaddr, dhit, halt);
    end
    if (dhit === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dload !== e.data) begin errors++; $display("FAIL halt_data_txn dload=%h want=%h", dload, e.data); end
      $display("TXN load addr=%h dload=%h", ramaddr, dload);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK); #1;
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
        errors++; $display("FAIL halt_after_data cyc=%0d REN=%b WEN=%b want 0/0", c, ramREN, ramWEN);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_load();
    test_store();
    test_error_retry();
    test_err_saturate();
    test_halt();
    test_halt_with_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
